// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_if
//  Purpose  : Byte-stream handshake plus IMEM write port of the boot loader.
//  Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        reload;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;

    modport master (
        output s_valid, s_data, reload,
        input  s_ready, imem_wr_en, imem_wr_addr, imem_wr_data
    );

    modport slave (
        input  s_valid, s_data, reload,
        output s_ready, imem_wr_en, imem_wr_addr, imem_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Assembles a counted little-endian byte stream into IMEM words
//             and holds the core in reset until the image is complete.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    imem_loader_if.slave  bus,
    output logic          core_rst_n,
    output logic          done,
    output logic          error
);

    localparam int unsigned                c_k_width = $clog2(DEPTH_WORDS + 1);
    localparam logic [c_k_width-1:0]       c_k_one   = c_k_width'(1);

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t                 r_state,      w_state;
    logic [1:0]             r_byte_idx,   w_byte_idx;
    logic [c_k_width-1:0]   r_k,          w_k;
    logic [31:0]            r_cnt,        w_cnt;
    logic [31:0]            r_word,       w_word;
    logic                   r_wr_en,      w_wr_en;
    logic [31:0]            r_wr_addr,    w_wr_addr;
    logic [31:0]            r_wr_data,    w_wr_data;
    logic                   r_core_rst_n, w_core_rst_n;
    logic                   r_done,       w_done;
    logic                   r_error,      w_error;

    logic                   w_ready;
    logic                   w_accept;
    logic [31:0]            w_cnt_ins;
    logic [31:0]            w_word_ins;

    assign w_ready  = (r_state == ST_HDR) || (r_state == ST_DATA);
    assign w_accept = bus.s_valid && w_ready;

    always_comb begin
        w_state      = r_state;
        w_byte_idx   = r_byte_idx;
        w_k          = r_k;
        w_cnt        = r_cnt;
        w_word       = r_word;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_addr;
        w_wr_data    = r_wr_data;
        w_core_rst_n = r_core_rst_n;
        w_done       = r_done;
        w_error      = r_error;

        // Current register with the incoming byte merged at its lane
        w_cnt_ins                       = r_cnt;
        w_cnt_ins[8*r_byte_idx +: 8]    = bus.s_data;
        w_word_ins                      = r_word;
        w_word_ins[8*r_byte_idx +: 8]   = bus.s_data;

        case (r_state)
            ST_HDR: begin
                if (w_accept) begin
                    w_cnt      = w_cnt_ins;
                    w_byte_idx = r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        if (w_cnt_ins == 32'd0) begin
                            w_state      = ST_DONE;
                            w_done       = 1'b1;
                            w_core_rst_n = 1'b1;
                        end else if (w_cnt_ins > 32'(DEPTH_WORDS)) begin
                            w_state = ST_ERR;
                            w_error = 1'b1;
                        end else begin
                            w_state = ST_DATA;
                            w_k     = '0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_word     = w_word_ins;
                    w_byte_idx = r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_word_ins;
                        w_wr_addr = BASE_ADDR + (32'(r_k) << 2);
                        w_state   = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                w_k = r_k + c_k_one;
                if ((32'(r_k) + 32'd1) == r_cnt) begin
                    w_state      = ST_DONE;
                    w_done       = 1'b1;
                    w_core_rst_n = 1'b1;
                end else begin
                    w_state = ST_DATA;
                end
            end
            ST_DONE, ST_ERR: begin
                if (bus.reload) begin
                    w_state      = ST_HDR;
                    w_done       = 1'b0;
                    w_error      = 1'b0;
                    w_core_rst_n = 1'b0;
                    w_byte_idx   = 2'd0;
                    w_k          = '0;
                end
            end
            default: begin
                w_state = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_HDR;
            r_byte_idx   <= 2'd0;
            r_k          <= '0;
            r_cnt        <= 32'd0;
            r_word       <= 32'd0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= BASE_ADDR;
            r_wr_data    <= 32'd0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_byte_idx   <= w_byte_idx;
            r_k          <= w_k;
            r_cnt        <= w_cnt;
            r_word       <= w_word;
            r_wr_en      <= w_wr_en;
            r_wr_addr    <= w_wr_addr;
            r_wr_data    <= w_wr_data;
            r_core_rst_n <= w_core_rst_n;
            r_done       <= w_done;
            r_error      <= w_error;
        end
    end

    assign bus.s_ready      = w_ready;
    assign bus.imem_wr_en   = r_wr_en;
    assign bus.imem_wr_addr = r_wr_addr;
    assign bus.imem_wr_data = r_wr_data;
    assign core_rst_n       = r_core_rst_n;
    assign done             = r_done;
    assign error            = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Randomised self-checking bench for the IMEM boot loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk;
    logic rst_n;
    logic core_rst_n;
    logic done;
    logic error;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] obs_q[$];
    int          ready_viol = 0;
    int          core_viol  = 0;

    // Write-port and invariant monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.imem_wr_en) begin
            obs_q.push_back({bus.imem_wr_addr, bus.imem_wr_data});
            if (bus.s_ready)  ready_viol++;
            if (core_rst_n)   core_viol++;
        end
        if (core_rst_n && !done) core_viol++;
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit noise);
        int gap;
        int t;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
            if (noise && $urandom_range(3, 0) == 0) bus.reload = 1'b1;
            @(posedge clk); #1;
            bus.reload = 1'b0;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        t = 0;
        @(negedge clk);
        while (!bus.s_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        checks++;
        if (!bus.s_ready) begin
            errors++;
            $display("FAIL accept_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, t);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_image(input logic [31:0] n, input logic [31:0] words[$],
                              input int max_gap, input bit noise);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], max_gap, noise);
        foreach (words[w])
            for (int i = 0; i < 4; i++) send_byte(words[w][8*i +: 8], max_gap, noise);
        bus.s_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        @(posedge clk); #1;
        bus.reload = 1'b0;
    endtask

    task automatic wait_settle();
        int t;
        t = 0;
        while (!(done || error) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (!(done || error)) begin
            errors++;
            $display("FAIL settle_timeout: done=%b error=%b, required one of them 1", done, error);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.reload  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.imem_wr_en !== 1'b0)   begin errors++; $display("FAIL rst_wr_en: got %b required 0", bus.imem_wr_en); end
        checks++; if (bus.imem_wr_addr !== BASE) begin errors++; $display("FAIL rst_wr_addr: got %h required %h", bus.imem_wr_addr, BASE); end
        checks++; if (bus.imem_wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_data: got %h required 0", bus.imem_wr_data); end
        checks++; if (core_rst_n !== 1'b0)       begin errors++; $display("FAIL rst_core_rst_n: got %b required 0", core_rst_n); end
        checks++; if (done !== 1'b0)             begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        checks++; if (error !== 1'b0)            begin errors++; $display("FAIL rst_error: got %b required 0", error); end
        checks++; if (bus.s_ready !== 1'b1)      begin errors++; $display("FAIL rst_s_ready: got %b required 1", bus.s_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] words[$];
        logic [63:0] exp_q[$];
        words = '{32'h1234_5678, 32'hDEAD_BEEF};
        foreach (words[i]) exp_q.push_back({BASE + 32'(i) * 32'd4, words[i]});
        obs_q.delete(); ready_viol = 0; core_viol = 0;
        send_image(32'd2, words, 0, 1'b0);
        checks++; if (bus.imem_wr_en !== 1'b1) begin errors++; $display("FAIL basic_last_strobe: got %b required 1", bus.imem_wr_en); end
        checks++; if (done !== 1'b0)           begin errors++; $display("FAIL basic_done_early: got %b required 0", done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1)           begin errors++; $display("FAIL basic_done: got %b required 1", done); end
        checks++; if (core_rst_n !== 1'b1)     begin errors++; $display("FAIL basic_core_rst_n: got %b required 1", core_rst_n); end
        checks++; if (bus.s_ready !== 1'b0)    begin errors++; $display("FAIL basic_ready_done: got %b required 0", bus.s_ready); end
        checks++; if (ready_viol !== 0)        begin errors++; $display("FAIL basic_ready_in_write: got %0d required 0", ready_viol); end
        checks++; if (core_viol !== 0)         begin errors++; $display("FAIL basic_core_rst_early: got %0d required 0", core_viol); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL basic_write_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_zero_count();
        logic [31:0] none[$];
        pulse_reload();
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reload_done: got %b required 0", done); end
        checks++; if (core_rst_n !== 1'b0)  begin errors++; $display("FAIL reload_core_rst_n: got %b required 0", core_rst_n); end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reload_ready: got %b required 1", bus.s_ready); end
        obs_q.delete();
        send_image(32'd0, none, 0, 1'b0);
        checks++; if (done !== 1'b1)        begin errors++; $display("FAIL zero_done: got %b required 1", done); end
        checks++; if (core_rst_n !== 1'b1)  begin errors++; $display("FAIL zero_core_rst_n: got %b required 1", core_rst_n); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL zero_ready: got %b required 0", bus.s_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (obs_q.size() != 0)    begin errors++; $display("FAIL zero_writes: got %0d required 0", obs_q.size()); end
    endtask

    task automatic test_overflow();
        logic [31:0] none[$];
        pulse_reload();
        obs_q.delete();
        send_image(32'(DEPTH + 1), none, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (error !== 1'b1)       begin errors++; $display("FAIL ovf_error: got %b required 1", error); end
        checks++; if (core_rst_n !== 1'b0)  begin errors++; $display("FAIL ovf_core_rst_n: got %b required 0", core_rst_n); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b required 0", bus.s_ready); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL ovf_done: got %b required 0", done); end
        checks++; if (obs_q.size() != 0)    begin errors++; $display("FAIL ovf_writes: got %0d required 0", obs_q.size()); end
        pulse_reload();
        checks++; if (error !== 1'b0)       begin errors++; $display("FAIL ovf_reload_error: got %b required 0", error); end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL ovf_reload_ready: got %b required 1", bus.s_ready); end
    endtask

    // Loads a random image from DONE/ERR (or HDR when reload_first is 0) and checks it
    task automatic test_image(input string name, input bit reload_first, input logic [31:0] words[$],
                              input int max_gap, input bit noise);
        logic [63:0] exp_q[$];
        if (reload_first) pulse_reload();
        foreach (words[i]) exp_q.push_back({BASE + 32'(i) * 32'd4, words[i]});
        obs_q.delete(); ready_viol = 0; core_viol = 0;
        send_image(32'(words.size()), words, max_gap, noise);
        wait_settle();
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL %s_status: done=%b error=%b required done=1 error=0", name, done, error); end
        checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL %s_core_rst_n: got %b required 1", name, core_rst_n); end
        checks++; if (ready_viol + core_viol != 0) begin errors++; $display("FAIL %s_invariants: got %0d violations required 0", name, ready_viol + core_viol); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL %s_write_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_write[%0d]: got %h required %h", name, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_gaps();
        logic [31:0] words[$];
        words = '{32'h1234_5678, 32'hDEAD_BEEF};
        test_image("gaps", 1'b0, words, 5, 1'b0);
    endtask

    task automatic test_reload();
        logic [31:0] words[$];
        words = '{32'h0000_0013};
        pulse_reload();
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reload_core_low: got %b required 0", core_rst_n); end
        test_image("reload", 1'b0, words, 2, 1'b0);
    endtask

    task automatic test_midword_reset();
        logic [31:0] words[$];
        pulse_reload();
        obs_q.delete();
        send_byte(8'h02, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0); send_byte(8'hBB, 0, 1'b0);
        bus.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_wr_en !== 1'b0)    begin errors++; $display("FAIL mid_rst_wr_en: got %b required 0", bus.imem_wr_en); end
        checks++; if (bus.imem_wr_addr !== BASE)  begin errors++; $display("FAIL mid_rst_addr: got %h required %h", bus.imem_wr_addr, BASE); end
        checks++; if (bus.imem_wr_data !== 32'd0) begin errors++; $display("FAIL mid_rst_data: got %h required 0", bus.imem_wr_data); end
        checks++; if (core_rst_n !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL mid_rst_status: core_rst_n=%b done=%b error=%b required all 0", core_rst_n, done, error);
        end
        checks++; if (bus.s_ready !== 1'b1)       begin errors++; $display("FAIL mid_rst_ready: got %b required 1", bus.s_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (obs_q.size() != 0)          begin errors++; $display("FAIL mid_rst_writes: got %0d required 0", obs_q.size()); end
        words = '{32'($urandom), 32'($urandom)};
        test_image("after_rst", 1'b0, words, 1, 1'b0);
    endtask

    task automatic test_random_images();
        for (int it = 0; it < 5; it++) begin
            logic [31:0] words[$];
            int n;
            n = int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++) words.push_back(32'($urandom));
            test_image("random", 1'b1, words, 3, 1'b1);
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] words[$];
        for (int i = 0; i < int'(DEPTH); i++) words.push_back(32'($urandom));
        test_image("full", 1'b1, words, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_overflow();
        test_gaps();
        test_reload();
        test_midword_reset();
        test_random_images();
        test_full_depth();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
